// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: slews H-bridge duty toward commanded targets with safe, dead-timed reversals and emergency stop
// Ports:
//   CLK, RST_N            clock, synchronous active-low reset
//   CMD_VALID/CMD_READY   command handshake carrying CMD_DIR (0 fwd, 1 rev) and CMD_DUTY
//   ESTOP                 level-sensitive emergency stop
//   Mode, Duty            registered drive pair (01 fwd, 11 rev, 10 brake)
//   AT_TARGET             running and Duty equals the latched target
module motor_ramp_ctrl #(
  parameter int RAMP_DIV    = 4,
  parameter int STEP        = 16,
  parameter int DEAD_CYCLES = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic       CMD_DIR,
  input  logic [7:0] CMD_DUTY,
  input  logic       ESTOP,
  output logic [1:0] Mode,
  output logic [7:0] Duty,
  output logic       AT_TARGET
);
  localparam int PW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  localparam int DW = DEAD_CYCLES > 1 ? $clog2(DEAD_CYCLES) : 1;
  typedef enum logic [1:0] {RUN, RAMP_DOWN, DEAD, STOP} state_t;
  state_t state_q;
  logic [PW-1:0] pre_q;
  logic [DW-1:0] dead_q;
  logic [1:0] mode_q;
  logic [7:0] duty_q, tgt_q, pend_duty_q, ramp_tgt, duty_d;
  logic pend_dir_q, tick, acc;
  logic [8:0] up, dn;
  assign tick = pre_q == PW'(RAMP_DIV - 1);
  assign CMD_READY = (state_q == RUN || state_q == RAMP_DOWN) && !ESTOP;
  assign acc = CMD_VALID && CMD_READY;
  assign Mode = mode_q;
  assign Duty = duty_q;
  assign AT_TARGET = state_q == RUN && duty_q == tgt_q;
  // A reversal in progress always ramps toward zero; the pending duty only applies after the brake.
  assign ramp_tgt = state_q == RAMP_DOWN ? 8'd0 : tgt_q;
  // 9-bit sums so saturation at the target is detected before any wrap or underflow.
  assign up = {1'b0, duty_q} + 9'(STEP);
  assign dn = {1'b0, duty_q} - 9'(STEP);
  assign duty_d = !tick ? duty_q :
                  duty_q < ramp_tgt ? (up > {1'b0, ramp_tgt} ? ramp_tgt : up[7:0]) :
                  duty_q > ramp_tgt ? ((dn[8] || dn[7:0] < ramp_tgt) ? ramp_tgt : dn[7:0]) :
                  duty_q;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= RUN;
      mode_q      <= 2'b01;
      duty_q      <= 8'd0;
      tgt_q       <= 8'd0;
      pend_dir_q  <= 1'b0;
      pend_duty_q <= 8'd0;
      pre_q       <= '0;
      dead_q      <= '0;
    end else if (ESTOP) begin
      state_q     <= STOP;
      mode_q      <= 2'b10;
      duty_q      <= 8'd0;
      pre_q       <= '0;
      pend_dir_q  <= 1'b0;
      pend_duty_q <= 8'd0;
    end else begin
      pre_q <= tick ? '0 : pre_q + PW'(1);
      case (state_q)
        RUN: begin
          duty_q <= duty_d;
          if (acc && (CMD_DIR == mode_q[1] || duty_q == 8'd0)) begin
            tgt_q  <= CMD_DUTY;
            mode_q <= {CMD_DIR, 1'b1};
          end else if (acc) begin
            pend_dir_q  <= CMD_DIR;
            pend_duty_q <= CMD_DUTY;
            state_q     <= RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          duty_q <= duty_d;
          if (acc && CMD_DIR == mode_q[1]) begin
            tgt_q   <= CMD_DUTY;
            state_q <= RUN;
          end else begin
            if (acc) pend_duty_q <= CMD_DUTY;
            if (duty_d == 8'd0) begin
              state_q <= DEAD;
              mode_q  <= 2'b10;
              dead_q  <= DW'(DEAD_CYCLES - 1);
            end
          end
        end
        DEAD: begin
          duty_q <= 8'd0;
          if (dead_q == '0) begin
            state_q <= RUN;
            mode_q  <= {pend_dir_q, 1'b1};
            tgt_q   <= pend_duty_q;
          end else begin
            dead_q <= dead_q - DW'(1);
          end
        end
        STOP: begin
          state_q <= RUN;
          mode_q  <= 2'b01;
          tgt_q   <= 8'd0;
          duty_q  <= 8'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// tb_motor_ramp_ctrl: scoreboard bench for motor_ramp_ctrl output transitions plus directed handshake and timing checks
module tb_motor_ramp_ctrl;
  logic CLK = 0, RST_N = 0, CMD_VALID = 0, CMD_DIR = 0, ESTOP = 0;
  logic [7:0] CMD_DUTY = 0;
  logic CMD_READY, AT_TARGET;
  logic [1:0] Mode;
  logic [7:0] Duty;
  logic v2 = 0, dir2 = 0;
  logic [7:0] duty2 = 0;
  logic ready2, at2;
  logic [1:0] mode2;
  logic [7:0] d2;
  typedef struct {logic [1:0] m; logic [7:0] d; int gap;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0, cyc = 0, last_cyc = 0;
  bit mon_en = 0;
  logic [9:0] last;
  motor_ramp_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_DIR(CMD_DIR), .CMD_DUTY(CMD_DUTY), .ESTOP(ESTOP),
    .Mode(Mode), .Duty(Duty), .AT_TARGET(AT_TARGET)
  );
  motor_ramp_ctrl #(.STEP(255)) u2 (
    .CLK(CLK), .RST_N(RST_N), .CMD_VALID(v2), .CMD_READY(ready2),
    .CMD_DIR(dir2), .CMD_DUTY(duty2), .ESTOP(ESTOP),
    .Mode(mode2), .Duty(d2), .AT_TARGET(at2)
  );
  always #5 CLK = ~CLK;
  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  task automatic push(logic [1:0] m, logic [7:0] d, int gap);
    exp_t e;
    e.m = m; e.d = d; e.gap = gap;
    q.push_back(e);
  endtask
  always @(negedge CLK) begin
    exp_t e;
    cyc++;
    if (mon_en && {Mode, Duty} !== last) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_change actual=mode %0d duty %0d required=no change", Mode, Duty);
      end else begin
        e = q.pop_front();
        chk("sb_mode", 32'(Mode), 32'(e.m));
        chk("sb_duty", 32'(Duty), 32'(e.d));
        if (e.gap != 0) chk("sb_gap", 32'(cyc - last_cyc), 32'(e.gap));
      end
      last_cyc = cyc;
    end
    last = {Mode, Duty};
  end
  task automatic send(logic dir, logic [7:0] duty);
    @(negedge CLK);
    CMD_VALID = 1; CMD_DIR = dir; CMD_DUTY = duty;
    for (int i = 0; i < 60; i++) begin
      if (CMD_READY) break;
      @(negedge CLK);
    end
    chk("cmd_accept", 32'(CMD_READY), 1);
    @(posedge CLK);
    #1 CMD_VALID = 0;
  endtask
  task automatic send2(logic dir, logic [7:0] duty);
    @(negedge CLK);
    v2 = 1; dir2 = dir; duty2 = duty;
    for (int i = 0; i < 60; i++) begin
      if (ready2) break;
      @(negedge CLK);
    end
    chk("cmd2_accept", 32'(ready2), 1);
    @(posedge CLK);
    #1 v2 = 0;
  endtask
  task automatic wait_duty(logic [7:0] d);
    for (int i = 0; i < 60 && Duty !== d; i++) @(negedge CLK);
  endtask
  task automatic wait_mode(logic [1:0] m);
    for (int i = 0; i < 60 && Mode !== m; i++) @(negedge CLK);
  endtask
  task automatic wait_d2_not(logic [7:0] d);
    for (int i = 0; i < 20 && d2 === d; i++) @(negedge CLK);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge CLK);
    chk("rst_mode", 32'(Mode), 1);
    chk("rst_duty", 32'(Duty), 0);
    chk("rst_at_target", 32'(AT_TARGET), 1);
    chk("rst_ready", 32'(CMD_READY), 1);
    mon_en = 1;
    RST_N = 1;
    push(1, 16, 0); push(1, 32, 4); push(1, 48, 4); push(1, 64, 4);
    send(0, 64);
    repeat (20) @(negedge CLK);
    chk("fwd64_at_target", 32'(AT_TARGET), 1);
    chk("fwd64_mode", 32'(Mode), 1);
    push(1, 48, 0); push(1, 32, 4); push(1, 16, 4); push(1, 0, 4);
    send(0, 0);
    repeat (20) @(negedge CLK);
    push(1, 16, 0); push(1, 32, 4); push(1, 40, 4);
    send(0, 40);
    repeat (16) @(negedge CLK);
    chk("fwd40_at_target", 32'(AT_TARGET), 1);
    chk("fwd40_duty", 32'(Duty), 40);
    push(1, 24, 0); push(1, 8, 4); push(1, 0, 4);
    send(0, 0);
    repeat (16) @(negedge CLK);
    push(1, 16, 0); push(1, 32, 4);
    send(0, 32);
    repeat (12) @(negedge CLK);
    push(1, 16, 0);
    send(1, 48);
    wait_duty(16);
    chk("cancel_duty16", 32'(Duty), 16);
    for (int v = 32; v <= 96; v += 16) push(1, 8'(v), 4);
    push(1, 100, 4);
    send(0, 100);
    repeat (30) @(negedge CLK);
    chk("cancel_at_target", 32'(AT_TARGET), 1);
    chk("cancel_mode", 32'(Mode), 1);
    push(1, 84, 0); push(1, 68, 4); push(1, 52, 4); push(1, 36, 4); push(1, 32, 4);
    send(0, 32);
    repeat (24) @(negedge CLK);
    push(1, 16, 0); push(2, 0, 4); push(3, 0, 8); push(3, 16, 4); push(3, 32, 4); push(3, 48, 4);
    send(1, 48);
    wait_mode(2);
    chk("dead_ready", 32'(CMD_READY), 0);
    chk("dead_duty", 32'(Duty), 0);
    n = 0;
    while (Mode === 2'b10 && n < 30) begin
      n++;
      @(negedge CLK);
    end
    chk("dead_len", 32'(n), 8);
    repeat (16) @(negedge CLK);
    chk("rev48_at_target", 32'(AT_TARGET), 1);
    push(3, 64, 0);
    for (int v = 80; v <= 192; v += 16) push(3, 8'(v), 4);
    push(3, 200, 4);
    send(1, 200);
    repeat (48) @(negedge CLK);
    chk("rev200_duty", 32'(Duty), 200);
    push(2, 0, 0); push(1, 0, 3);
    @(negedge CLK);
    ESTOP = 1;
    @(negedge CLK);
    chk("estop_duty", 32'(Duty), 0);
    chk("estop_mode", 32'(Mode), 2);
    chk("estop_ready", 32'(CMD_READY), 0);
    repeat (2) @(negedge CLK);
    ESTOP = 0;
    @(negedge CLK);
    chk("release_mode", 32'(Mode), 1);
    chk("release_duty", 32'(Duty), 0);
    chk("release_ready", 32'(CMD_READY), 1);
    chk("release_at_target", 32'(AT_TARGET), 1);
    push(1, 16, 0); push(1, 32, 4);
    send(0, 32);
    repeat (12) @(negedge CLK);
    push(1, 16, 0); push(2, 0, 4); push(1, 0, 0);
    send(1, 16);
    wait_mode(2);
    chk("dead2_mode", 32'(Mode), 2);
    repeat (2) @(negedge CLK);
    RST_N = 0;
    @(negedge CLK);
    RST_N = 1;
    chk("dead_rst_mode", 32'(Mode), 1);
    chk("dead_rst_duty", 32'(Duty), 0);
    chk("dead_rst_at_target", 32'(AT_TARGET), 1);
    repeat (20) @(negedge CLK);
    chk("dead_rst_stays_mode", 32'(Mode), 1);
    send2(0, 100);
    wait_d2_not(0);
    chk("s255_clamp_up", 32'(d2), 100);
    send2(0, 255);
    wait_d2_not(100);
    chk("s255_no_wrap", 32'(d2), 255);
    chk("s255_mode", 32'(mode2), 1);
    send2(0, 0);
    wait_d2_not(255);
    chk("s255_no_underflow", 32'(d2), 0);
    repeat (4) @(negedge CLK);
    chk("queue_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
